lieat_exu_wbarb: RTL and testbench

- Parametrised N-channel writeback arbiter with a registered output stage; generalises the fixed five-source execute-stage writeback merge.
- Collects completed results from the execution units (com, lsu, muldiv, vpu, fpu and any future unit) and issues at most one writeback per cycle to the register file and the forwarding network.
- Adds a selectable fixed-priority or round-robin policy, downstream stall backpressure, rd==x0 write suppression and a saturating conflict counter.

---
 rtl/lieat_exu_wbarb.sv | 142 ++++++++++++++
 tb/tb_lieat_exu_wbarb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_exu_wbarb.sv
// lieat_exu_wbarb: N-channel execute-stage writeback arbiter.
//
// Collects completed results from the execution units and issues at most one
// writeback per cycle through a registered output stage. Arbitration is either
// fixed priority (channel 0 highest) or round-robin, selected by RR_MODE.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   ch_valid/ready   per-channel result handshake (ready is combinational)
//   ch_pc/en/rd/data per-channel result payload, channel i at [i*W +: W]
//   ch_tag           per-channel sideband: bit0 = lsu/mmio, bit1 = ebreak
//   wb_stall         downstream cannot take a new writeback
//   wbck_o_*         registered writeback (valid, source channel, payload)
//   conflict_cnt     saturating count of cycles with two or more requesters
module lieat_exu_wbarb #(
   parameter int unsigned NCH     = 5,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RIDX    = 5,
   parameter int unsigned RR_MODE = 1,
   parameter int unsigned CNTW    = 16,
   localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NCH-1:0]      ch_valid,
   output logic [NCH-1:0]      ch_ready,
   input  logic [NCH*XLEN-1:0] ch_pc,
   input  logic [NCH-1:0]      ch_en,
   input  logic [NCH*RIDX-1:0] ch_rd,
   input  logic [NCH*XLEN-1:0] ch_data,
   input  logic [NCH*2-1:0]    ch_tag,
   input  logic                wb_stall,
   output logic                wbck_o_valid,
   output logic [CW-1:0]       wbck_o_ch,
   output logic [XLEN-1:0]     wbck_o_pc,
   output logic                wbck_o_en,
   output logic [RIDX-1:0]     wbck_o_rd,
   output logic [XLEN-1:0]     wbck_o_data,
   output logic                wbck_o_lsu,
   output logic                wbck_o_ebreak,
   output logic [CNTW-1:0]     conflict_cnt
);

   logic [CW-1:0]   rr_ptr;
   logic [CW-1:0]   gidx;
   logic            gany;
   logic            load;
   logic            multi_req;
   int unsigned     nreq;
   logic [XLEN-1:0] sel_pc;
   logic [XLEN-1:0] sel_data;
   logic [RIDX-1:0] sel_rd;
   logic            sel_en;
   logic [1:0]      sel_tag;

   assign load = !wbck_o_valid || !wb_stall;

   // Grant search. The first pass only considers channels at or above rr_ptr
   // (every channel in fixed-priority mode); the second pass supplies the
   // wrap-around to the channels below rr_ptr.
   always_comb begin
      gany = 1'b0;
      gidx = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!gany && ch_valid[i] && (RR_MODE == 0 || CW'(i) >= rr_ptr)) begin
            gany = 1'b1;
            gidx = CW'(i);
         end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!gany && ch_valid[i]) begin
            gany = 1'b1;
            gidx = CW'(i);
         end
      end
   end

   // Payload mux for the granted channel.
   always_comb begin
      sel_pc   = '0;
      sel_data = '0;
      sel_rd   = '0;
      sel_en   = 1'b0;
      sel_tag  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (gidx == CW'(i)) begin
            sel_pc   = ch_pc[i*XLEN +: XLEN];
            sel_data = ch_data[i*XLEN +: XLEN];
            sel_rd   = ch_rd[i*RIDX +: RIDX];
            sel_en   = ch_en[i];
            sel_tag  = ch_tag[i*2 +: 2];
         end
      end
   end

   // Ready is gated by reset so no source sees an acceptance that is dropped.
   always_comb begin
      ch_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         ch_ready[i] = reset && load && gany && (gidx == CW'(i));
      end
   end

   always_comb begin
      nreq = 0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (ch_valid[i]) nreq = nreq + 1;
      end
      multi_req = (nreq >= 2);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wbck_o_valid  <= 1'b0;
         wbck_o_ch     <= '0;
         wbck_o_pc     <= '0;
         wbck_o_en     <= 1'b0;
         wbck_o_rd     <= '0;
         wbck_o_data   <= '0;
         wbck_o_lsu    <= 1'b0;
         wbck_o_ebreak <= 1'b0;
         conflict_cnt  <= '0;
         rr_ptr        <= '0;
      end else begin
         if (multi_req && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNTW'(1);
         if (load) begin
            wbck_o_valid <= gany;
            if (gany) begin
               wbck_o_ch     <= gidx;
               wbck_o_pc     <= sel_pc;
               wbck_o_en     <= sel_en && (sel_rd != '0);
               wbck_o_rd     <= sel_rd;
               wbck_o_data   <= sel_data;
               wbck_o_lsu    <= sel_tag[0];
               wbck_o_ebreak <= sel_tag[1];
               rr_ptr        <= (gidx == CW'(NCH - 1)) ? '0 : gidx + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_lieat_exu_wbarb.sv
// Bench for lieat_exu_wbarb: one fixed-priority and one round-robin instance,
// each driven by its own set of sources and compared against a transaction
// level reference model every cycle.
module tb_lieat_exu_wbarb;

   localparam int NCH  = 5;
   localparam int XLEN = 32;
   localparam int RIDX = 5;
   localparam int CNTW = 4;

   typedef struct {
      logic            v;
      logic [XLEN-1:0] pc;
      logic            en;
      logic [RIDX-1:0] rd;
      logic [XLEN-1:0] data;
      logic [1:0]      tag;
   } txn_t;

   typedef struct {
      bit   v;
      int   ch;
      txn_t t;
   } out_t;

   logic clock = 1'b0;
   logic reset;
   logic wb_stall;

   logic [NCH-1:0]      valid [2];
   logic [NCH-1:0]      ready [2];
   logic [NCH-1:0]      en    [2];
   logic [NCH*XLEN-1:0] pc    [2];
   logic [NCH*XLEN-1:0] data  [2];
   logic [NCH*RIDX-1:0] rd    [2];
   logic [NCH*2-1:0]    tag   [2];

   logic            o_valid  [2];
   logic [2:0]      o_ch     [2];
   logic [XLEN-1:0] o_pc     [2];
   logic            o_en     [2];
   logic [RIDX-1:0] o_rd     [2];
   logic [XLEN-1:0] o_data   [2];
   logic            o_lsu    [2];
   logic            o_ebreak [2];
   logic [CNTW-1:0] o_cnt    [2];

   txn_t        src  [2][NCH];
   out_t        mo   [2];
   int unsigned mrr  [2];
   int unsigned mcnt [2];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   lieat_exu_wbarb #(.NCH(NCH), .XLEN(XLEN), .RIDX(RIDX), .RR_MODE(0), .CNTW(CNTW)) u_fp (
      .clock(clock), .reset(reset),
      .ch_valid(valid[0]), .ch_ready(ready[0]), .ch_pc(pc[0]), .ch_en(en[0]),
      .ch_rd(rd[0]), .ch_data(data[0]), .ch_tag(tag[0]), .wb_stall(wb_stall),
      .wbck_o_valid(o_valid[0]), .wbck_o_ch(o_ch[0]), .wbck_o_pc(o_pc[0]),
      .wbck_o_en(o_en[0]), .wbck_o_rd(o_rd[0]), .wbck_o_data(o_data[0]),
      .wbck_o_lsu(o_lsu[0]), .wbck_o_ebreak(o_ebreak[0]), .conflict_cnt(o_cnt[0])
   );

   lieat_exu_wbarb #(.NCH(NCH), .XLEN(XLEN), .RIDX(RIDX), .RR_MODE(1), .CNTW(CNTW)) u_rr (
      .clock(clock), .reset(reset),
      .ch_valid(valid[1]), .ch_ready(ready[1]), .ch_pc(pc[1]), .ch_en(en[1]),
      .ch_rd(rd[1]), .ch_data(data[1]), .ch_tag(tag[1]), .wb_stall(wb_stall),
      .wbck_o_valid(o_valid[1]), .wbck_o_ch(o_ch[1]), .wbck_o_pc(o_pc[1]),
      .wbck_o_en(o_en[1]), .wbck_o_rd(o_rd[1]), .wbck_o_data(o_data[1]),
      .wbck_o_lsu(o_lsu[1]), .wbck_o_ebreak(o_ebreak[1]), .conflict_cnt(o_cnt[1])
   );

   task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, obs, exp, $time);
      end
   endtask

   function automatic string tg(int m, string s);
      return {(m == 1) ? "rr." : "fp.", s};
   endfunction

   function automatic txn_t rnd();
      txn_t t;
      t.v    = 1'b1;
      t.pc   = $urandom;
      t.en   = 1'($urandom_range(0, 1));
      t.rd   = ($urandom_range(0, 3) == 0) ? '0 : RIDX'($urandom_range(0, 31));
      t.data = $urandom;
      t.tag  = 2'($urandom_range(0, 3));
      return t;
   endfunction

   task automatic put(int i, txn_t t);
      src[0][i] = t;
      src[1][i] = t;
   endtask

   task automatic clear_src();
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < NCH; i++) src[m][i].v = 1'b0;
   endtask

   task automatic drive();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < NCH; i++) begin
            valid[m][i]              = src[m][i].v;
            en[m][i]                 = src[m][i].en;
            pc[m][i*XLEN +: XLEN]    = src[m][i].pc;
            data[m][i*XLEN +: XLEN]  = src[m][i].data;
            rd[m][i*RIDX +: RIDX]    = src[m][i].rd;
            tag[m][i*2 +: 2]         = src[m][i].tag;
         end
      end
   endtask

   // Reference grant: walk the channels in policy order and take the first
   // one that is presenting a result.
   function automatic int pick(int m);
      for (int k = 0; k < NCH; k++) begin
         int idx;
         idx = (m == 1) ? int'((mrr[1] + k) % NCH) : k;
         if (src[m][idx].v) return idx;
      end
      return -1;
   endfunction

   // One clock cycle: check the handshake mid-cycle, advance the model across
   // the edge, then check the registered outputs.
   task automatic step();
      int             g    [2];
      bit             ld   [2];
      logic [NCH-1:0] er   [2];
      logic [NCH-1:0] seen [2];
      int             nv;
      drive();
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
         g[m]    = pick(m);
         ld[m]   = !mo[m].v || !wb_stall;
         er[m]   = (g[m] >= 0 && ld[m]) ? (NCH'(1) << g[m]) : '0;
         seen[m] = ready[m];
         chk(tg(m, "ready"), 64'(ready[m]), 64'(er[m]));
      end
      @(posedge clock);
      #1;
      for (int m = 0; m < 2; m++) begin
         nv = 0;
         for (int i = 0; i < NCH; i++) if (src[m][i].v) nv++;
         if (nv >= 2 && mcnt[m] < (1 << CNTW) - 1) mcnt[m]++;
         if (ld[m]) begin
            mo[m].v = (g[m] >= 0);
            if (g[m] >= 0) begin
               mo[m].ch   = g[m];
               mo[m].t    = src[m][g[m]];
               mo[m].t.en = src[m][g[m]].en && (src[m][g[m]].rd != '0);
               mrr[m]     = (g[m] + 1) % NCH;
            end
         end
         for (int i = 0; i < NCH; i++) if (seen[m][i]) src[m][i].v = 1'b0;
         chk(tg(m, "valid"), 64'(o_valid[m]), 64'(mo[m].v));
         chk(tg(m, "cnt"), 64'(o_cnt[m]), 64'(mcnt[m]));
         if (mo[m].v) begin
            chk(tg(m, "ctl"), 64'({o_ch[m], o_en[m], o_rd[m], o_lsu[m], o_ebreak[m]}),
                64'({3'(mo[m].ch), mo[m].t.en, mo[m].t.rd, mo[m].t.tag[0], mo[m].t.tag[1]}));
            chk(tg(m, "pc"), 64'(o_pc[m]), 64'(mo[m].t.pc));
            chk(tg(m, "data"), 64'(o_data[m]), 64'(mo[m].t.data));
         end
      end
   endtask

   initial begin
      int   fp_seq [3];
      int   cnt0;
      txn_t t;

      fp_seq[0] = 1;
      fp_seq[1] = 2;
      fp_seq[2] = 4;
      reset     = 1'b1;
      wb_stall  = 1'b0;
      clear_src();
      drive();
      #1 reset = 1'b0;

      // Reset held with every channel requesting.
      for (int i = 0; i < NCH; i++) put(i, rnd());
      drive();
      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
         chk(tg(m, "rst.ready"), 64'(ready[m]), 64'(0));
         chk(tg(m, "rst.valid"), 64'(o_valid[m]), 64'(0));
         chk(tg(m, "rst.cnt"), 64'(o_cnt[m]), 64'(0));
         chk(tg(m, "rst.pc"), 64'(o_pc[m]), 64'(0));
         chk(tg(m, "rst.data"), 64'(o_data[m]), 64'(0));
         mo[m].v = 1'b0;
         mrr[m]  = 0;
         mcnt[m] = 0;
      end
      @(posedge clock);
      #1 reset = 1'b1;

      step();
      for (int m = 0; m < 2; m++) chk(tg(m, "first.ch"), 64'(o_ch[m]), 64'(0));

      // Fixed priority over channels 1, 2 and 4.
      clear_src();
      put(1, rnd());
      put(2, rnd());
      put(4, rnd());
      cnt0 = int'(mcnt[0]);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("fp.seq", 64'(o_ch[0]), 64'(fp_seq[k]));
      end
      chk("fp.conf", 64'(o_cnt[0]), 64'(cnt0 + 2));

      // Round-robin with every channel re-presenting.
      clear_src();
      for (int i = 0; i < NCH; i++) put(i, rnd());
      for (int k = 0; k < 10; k++) begin
         step();
         chk("rr.seq", 64'(o_ch[1]), 64'(k % NCH));
         chk("fp.hog", 64'(o_ch[0]), 64'(0));
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < NCH; i++) if (!src[m][i].v) src[m][i] = rnd();
      end

      // Pointer wrap: grant ch2 leaves the pointer at 3, then ch1/ch4 compete.
      clear_src();
      put(2, rnd());
      step();
      put(1, rnd());
      put(4, rnd());
      step();
      chk("rr.wrap4", 64'(o_ch[1]), 64'(4));
      step();
      chk("rr.wrap1", 64'(o_ch[1]), 64'(1));

      // Stall holds the output and blocks a waiting channel.
      clear_src();
      t.v = 1'b1; t.pc = 32'h8000_0010; t.en = 1'b1; t.rd = 5'd7;
      t.data = 32'hDEAD_BEEF; t.tag = 2'b00;
      put(2, t);
      step();
      put(0, rnd());
      wb_stall = 1'b1;
      repeat (4) begin
         step();
         for (int m = 0; m < 2; m++) begin
            chk(tg(m, "stall.pc"), 64'(o_pc[m]), 64'h8000_0010);
            chk(tg(m, "stall.data"), 64'(o_data[m]), 64'hDEAD_BEEF);
            chk(tg(m, "stall.rd"), 64'(o_rd[m]), 64'(7));
            chk(tg(m, "stall.rdy0"), 64'(ready[m][0]), 64'(0));
         end
      end
      wb_stall = 1'b0;
      step();
      for (int m = 0; m < 2; m++) chk(tg(m, "unstall.ch"), 64'(o_ch[m]), 64'(0));

      // Stall with an empty output register still accepts.
      clear_src();
      step();
      wb_stall = 1'b1;
      put(1, rnd());
      step();
      for (int m = 0; m < 2; m++) begin
         chk(tg(m, "empty.valid"), 64'(o_valid[m]), 64'(1));
         chk(tg(m, "empty.ch"), 64'(o_ch[m]), 64'(1));
      end
      wb_stall = 1'b0;
      step();

      // rd == x0 suppresses the write; tags pass through.
      clear_src();
      t = rnd();
      t.en = 1'b1; t.rd = '0; t.tag = 2'b10;
      put(3, t);
      step();
      for (int m = 0; m < 2; m++) begin
         chk(tg(m, "x0.en"), 64'(o_en[m]), 64'(0));
         chk(tg(m, "x0.ebreak"), 64'(o_ebreak[m]), 64'(1));
         chk(tg(m, "x0.lsu"), 64'(o_lsu[m]), 64'(0));
      end

      // Random traffic with random stalls.
      repeat (400) begin
         wb_stall = ($urandom_range(0, 3) == 0);
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < NCH; i++)
               if (!src[m][i].v && $urandom_range(0, 1) == 1) src[m][i] = rnd();
         step();
      end
      for (int m = 0; m < 2; m++) chk(tg(m, "cnt.sat"), 64'(o_cnt[m]), 64'((1 << CNTW) - 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
